// File: rtl/picoblaze_io_pkg.sv
// Shared address map, PENDING layout and interrupt-controller state type
// for the PicoBlaze I/O hub.
package picoblaze_io_pkg;

  localparam logic [7:0] ADDR_IN_BASE  = 8'h00;
  localparam logic [7:0] ADDR_PENDING  = 8'h20;
  localparam logic [7:0] ADDR_MASK_RD  = 8'h21;
  localparam logic [7:0] ADDR_TIMER_RD = 8'h22;
  localparam logic [7:0] ADDR_OUT_BASE = 8'h40;
  localparam logic [7:0] ADDR_MASK_WR  = 8'h60;
  localparam logic [7:0] ADDR_PEND_W1C = 8'h61;
  localparam logic [7:0] ADDR_TIMER_WR = 8'h62;

  localparam int PEND_TIMER_BIT = 7;

  typedef enum logic {
    ST_ARMED     = 1'b0,
    ST_SERVICING = 1'b1
  } irq_state_e;

  // Bits of PENDING that physically exist: the external sources plus the timer.
  function automatic logic [7:0] pending_valid(input int num_irq);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 7; i++) begin
      if (i < num_irq) v[i] = 1'b1;
    end
    v[PEND_TIMER_BIT] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/picoblaze_io_irq_ctrl.sv
// Interrupt block: irq_src edge detect, PENDING (W1C, set wins), MASK and the
// ARMED/SERVICING request state machine.
//
//   state        | meaning
//   ST_ARMED     | raise interrupt when PENDING & MASK is non-zero, hold until ack
//   ST_SERVICING | interrupt held low until PENDING & MASK drains to zero
module picoblaze_io_irq_ctrl
  import picoblaze_io_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_src_i,
  input  logic               timer_evt_i,
  input  logic               mask_we_i,
  input  logic               w1c_we_i,
  input  logic [7:0]         wdata_i,
  input  logic               interrupt_ack_i,
  output logic [7:0]         pending_o,
  output logic [7:0]         mask_o,
  output logic               interrupt_o
);

  localparam logic [7:0] PEND_VALID = pending_valid(NUM_IRQ);

  logic [NUM_IRQ-1:0] hist_q;
  logic               primed_q;
  logic [7:0]         pending_q, pending_d;
  logic [7:0]         mask_q;
  logic [7:0]         set_vec;
  logic               irq_q;
  irq_state_e         state_q;
  logic               active;

  // primed_q stays low for the first cycle after reset so that a source that
  // is already high at release only loads the history and never looks like a rise.
  always_comb begin
    set_vec = '0;
    set_vec[NUM_IRQ-1:0] = primed_q ? (irq_src_i & ~hist_q) : '0;
    set_vec[PEND_TIMER_BIT] = timer_evt_i;
    pending_d = pending_q;
    if (w1c_we_i) pending_d = pending_d & ~wdata_i;
    pending_d = (pending_d | set_vec) & PEND_VALID;
  end

  assign active = |(pending_q & mask_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q    <= '0;
      primed_q  <= 1'b0;
      pending_q <= '0;
      mask_q    <= '0;
      irq_q     <= 1'b0;
      state_q   <= ST_ARMED;
    end else begin
      hist_q    <= irq_src_i;
      primed_q  <= 1'b1;
      pending_q <= pending_d;
      if (mask_we_i) mask_q <= wdata_i;
      case (state_q)
        ST_ARMED: begin
          if (irq_q && interrupt_ack_i) begin
            irq_q   <= 1'b0;
            state_q <= ST_SERVICING;
          end else if (active) begin
            irq_q <= 1'b1;
          end
        end
        ST_SERVICING: begin
          irq_q <= 1'b0;
          if (!active) state_q <= ST_ARMED;
        end
        default: begin
          irq_q   <= 1'b0;
          state_q <= ST_ARMED;
        end
      endcase
    end
  end

  assign pending_o   = pending_q;
  assign mask_o      = mask_q;
  assign interrupt_o = irq_q;

endmodule

// File: rtl/picoblaze_io_hub.sv
// KCPSM3 I/O hub: registered read mux, output registers, periodic timer and
// the interrupt controller behind a flat 8-bit port map.
module picoblaze_io_hub
  import picoblaze_io_pkg::*;
#(
  parameter int NUM_IN         = 4,
  parameter int NUM_OUT        = 4,
  parameter int NUM_IRQ        = 4,
  parameter int CLK_FREQ_IN_HZ = 25000000,
  parameter int TIMER_HZ       = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           port_id,
  input  logic                 write_strobe,
  input  logic [7:0]           out_port,
  output logic [7:0]           in_port,
  output logic                 interrupt,
  input  logic                 interrupt_ack,
  input  logic [8*NUM_IN-1:0]  in_data,
  output logic [8*NUM_OUT-1:0] out_data,
  input  logic [NUM_IRQ-1:0]   irq_src,
  output logic                 timer_tick
);

  localparam int TERM  = CLK_FREQ_IN_HZ / TIMER_HZ;
  localparam int CNT_W = (TERM > 1) ? $clog2(TERM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TERM - 1);

  logic [NUM_OUT-1:0][7:0] out_q, out_d;
  logic [7:0]              in_port_q, in_port_d;
  logic                    timer_en_q, timer_en_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    tick_q;
  logic                    wrap;
  logic                    mask_we, w1c_we;
  logic [7:0]              pending, mask;

  assign wrap = timer_en_q && (cnt_q == CNT_LAST);

  always_comb begin
    out_d      = out_q;
    timer_en_d = timer_en_q;
    mask_we    = 1'b0;
    w1c_we     = 1'b0;
    if (write_strobe) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (port_id == ADDR_OUT_BASE + 8'(i)) out_d[i] = out_port;
      end
      mask_we = (port_id == ADDR_MASK_WR);
      w1c_we  = (port_id == ADDR_PEND_W1C);
      if (port_id == ADDR_TIMER_WR) timer_en_d = out_port[0];
    end
  end

  always_comb begin
    in_port_d = 8'h00;
    for (int i = 0; i < NUM_IN; i++) begin
      if (port_id == ADDR_IN_BASE + 8'(i)) in_port_d = in_data[8*i +: 8];
    end
    case (port_id)
      ADDR_PENDING:  in_port_d = pending;
      ADDR_MASK_RD:  in_port_d = mask;
      ADDR_TIMER_RD: in_port_d = {7'b0, timer_en_q};
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!timer_en_q || wrap) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q      <= '0;
      in_port_q  <= '0;
      timer_en_q <= 1'b0;
      cnt_q      <= '0;
      tick_q     <= 1'b0;
    end else begin
      out_q      <= out_d;
      in_port_q  <= in_port_d;
      timer_en_q <= timer_en_d;
      cnt_q      <= cnt_d;
      tick_q     <= wrap;
    end
  end

  picoblaze_io_irq_ctrl #(
    .NUM_IRQ(NUM_IRQ)
  ) u_irq (
    .clk            (clk),
    .reset_n        (reset_n),
    .irq_src_i      (irq_src),
    .timer_evt_i    (wrap),
    .mask_we_i      (mask_we),
    .w1c_we_i       (w1c_we),
    .wdata_i        (out_port),
    .interrupt_ack_i(interrupt_ack),
    .pending_o      (pending),
    .mask_o         (mask),
    .interrupt_o    (interrupt)
  );

  assign out_data   = out_q;
  assign in_port    = in_port_q;
  assign timer_tick = tick_q;

endmodule

// File: tb/tb_picoblaze_io_hub.sv
// Self-checking bench for picoblaze_io_hub: read-map vector table through a
// scoreboard queue, plus hand sequences for writes, interrupts, timer and reset.
module tb_picoblaze_io_hub;

  localparam int NI = 4, NO = 4, NQ = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [7:0]    port_id;
  logic          write_strobe;
  logic [7:0]    out_port;
  logic [7:0]    in_port;
  logic          interrupt;
  logic          interrupt_ack;
  logic [8*NI-1:0] in_data;
  logic [8*NO-1:0] out_data;
  logic [NQ-1:0] irq_src;
  logic          timer_tick;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp;
    string      name;
  } rd_vec_t;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } sb_item_t;

  sb_item_t sb[$];
  rd_vec_t  vecs[11];

  picoblaze_io_hub #(
    .NUM_IN(NI), .NUM_OUT(NO), .NUM_IRQ(NQ),
    .CLK_FREQ_IN_HZ(10), .TIMER_HZ(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .port_id(port_id), .write_strobe(write_strobe),
    .out_port(out_port), .in_port(in_port), .interrupt(interrupt),
    .interrupt_ack(interrupt_ack), .in_data(in_data), .out_data(out_data),
    .irq_src(irq_src), .timer_tick(timer_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input string name);
    sb_item_t it;
    @(negedge clk);
    port_id = addr;
    it.exp = exp;
    it.name = name;
    sb.push_back(it);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      it = sb.pop_front();
      check(it.name, {24'b0, in_port}, {24'b0, it.exp});
    end
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    port_id = addr;
    out_port = data;
    write_strobe = 1'b1;
    @(posedge clk);
    #1;
    write_strobe = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_tick, last_tick, n_ticks, bad_gap;

    vecs[0]  = '{8'h00, 8'h11, "rd_ch0"};
    vecs[1]  = '{8'h01, 8'h22, "rd_ch1"};
    vecs[2]  = '{8'h02, 8'hC3, "rd_ch2"};
    vecs[3]  = '{8'h03, 8'h44, "rd_ch3"};
    vecs[4]  = '{8'h04, 8'h00, "rd_ch4_absent"};
    vecs[5]  = '{8'h7F, 8'h00, "rd_7f"};
    vecs[6]  = '{8'h20, 8'h00, "rd_pending_rst"};
    vecs[7]  = '{8'h21, 8'h00, "rd_mask_rst"};
    vecs[8]  = '{8'h22, 8'h00, "rd_timer_rst"};
    vecs[9]  = '{8'h41, 8'h00, "rd_outreg_unmapped"};
    vecs[10] = '{8'hFF, 8'h00, "rd_ff"};

    reset_n = 1'b0;
    port_id = 8'h00;
    write_strobe = 1'b0;
    out_port = 8'h00;
    interrupt_ack = 1'b0;
    in_data = 32'h44C3_2211;
    irq_src = '0;
    #3;
    check("rst_in_port", {24'b0, in_port}, 32'h0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_interrupt", {31'b0, interrupt}, 32'h0);
    check("rst_tick", {31'b0, timer_tick}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) rd(vecs[i].addr, vecs[i].exp, vecs[i].name);

    wr(8'h41, 8'h5A);
    check("wr_out1", out_data, 32'h0000_5A00);
    rd(8'h41, 8'h00, "rd_after_wr_41");
    @(negedge clk);
    port_id = 8'h40; out_port = 8'hFF; write_strobe = 1'b0;
    cycles(1);
    check("wr_no_strobe", out_data, 32'h0000_5A00);
    wr(8'h44, 8'hEE);
    check("wr_out_absent", out_data, 32'h0000_5A00);
    wr(8'h43, 8'hA5);
    check("wr_out3", out_data, 32'hA500_5A00);
    wr(8'h60, 8'hFF);
    rd(8'h21, 8'hFF, "rd_mask_ff");
    wr(8'h60, 8'h01);
    rd(8'h21, 8'h01, "rd_mask_01");

    // Ack with no request pending must leave the controller armed.
    @(negedge clk); interrupt_ack = 1'b1;
    cycles(1);
    @(negedge clk); interrupt_ack = 1'b0;
    check("ack_idle", {31'b0, interrupt}, 32'h0);

    @(negedge clk); irq_src[0] = 1'b1;
    cycles(1);
    check("irq_edge1", {31'b0, interrupt}, 32'h0);
    cycles(1);
    check("irq_edge2", {31'b0, interrupt}, 32'h1);
    rd(8'h20, 8'h01, "rd_pending_01");
    check("irq_held", {31'b0, interrupt}, 32'h1);
    @(negedge clk); interrupt_ack = 1'b1;
    cycles(1);
    interrupt_ack = 1'b0;
    check("irq_acked", {31'b0, interrupt}, 32'h0);
    cycles(5);
    check("irq_no_reassert", {31'b0, interrupt}, 32'h0);
    @(negedge clk); irq_src[0] = 1'b0;
    wr(8'h61, 8'h01);
    cycles(2);
    check("irq_after_w1c", {31'b0, interrupt}, 32'h0);
    rd(8'h20, 8'h00, "rd_pending_cleared");
    @(negedge clk); irq_src[0] = 1'b1;
    cycles(2);
    check("irq_rearm", {31'b0, interrupt}, 32'h1);
    @(negedge clk); interrupt_ack = 1'b1;
    cycles(1);
    interrupt_ack = 1'b0;
    @(negedge clk); irq_src[0] = 1'b0;
    wr(8'h61, 8'h01);
    cycles(2);

    // Set and W1C of bit 1 in the same cycle: the set wins.
    @(negedge clk);
    irq_src[1] = 1'b1;
    port_id = 8'h61; out_port = 8'h02; write_strobe = 1'b1;
    @(posedge clk); #1;
    write_strobe = 1'b0;
    rd(8'h20, 8'h02, "set_beats_w1c");
    wr(8'h61, 8'h02);
    rd(8'h20, 8'h00, "w1c_bit1");
    @(negedge clk); irq_src[1] = 1'b0;
    wr(8'h61, 8'hFF);
    rd(8'h20, 8'h00, "w1c_unused_bits");

    wr(8'h62, 8'h01);
    first_tick = -1; last_tick = -1; n_ticks = 0; bad_gap = 0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      if (timer_tick) begin
        if (first_tick < 0) first_tick = c;
        else if (c - last_tick != 10) bad_gap++;
        last_tick = c;
        n_ticks++;
      end
    end
    check("timer_first", first_tick, 32'd10);
    check("timer_count", n_ticks, 32'd4);
    check("timer_gap_err", bad_gap, 32'd0);
    rd(8'h22, 8'h01, "rd_timer_en");
    rd(8'h20, 8'h80, "pending_timer");
    check("timer_masked_no_irq", {31'b0, interrupt}, 32'h0);
    wr(8'h62, 8'h00);
    n_ticks = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (timer_tick) n_ticks++;
    end
    check("timer_off_ticks", n_ticks, 32'd0);
    wr(8'h61, 8'h80);
    rd(8'h20, 8'h00, "pending_timer_clr");

    @(negedge clk); irq_src[0] = 1'b1;
    cycles(2);
    check("pre_reset_irq", {31'b0, interrupt}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_interrupt", {31'b0, interrupt}, 32'h0);
    check("mid_rst_out_data", out_data, 32'h0);
    check("mid_rst_in_port", {24'b0, in_port}, 32'h0);
    check("mid_rst_tick", {31'b0, timer_tick}, 32'h0);
    @(negedge clk); reset_n = 1'b1;
    wr(8'h60, 8'h01);
    cycles(4);
    check("post_rst_no_irq", {31'b0, interrupt}, 32'h0);
    rd(8'h20, 8'h00, "post_rst_pending");

    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
